collision_judge: RTL and testbench

COLLISION_JUDGE -- requirements
Module: collision_judge

---
 rtl/ddr_pkg.sv | 19 +
 rtl/lane_judge.sv | 72 +++++++
 rtl/collision_judge.sv | 129 ++++++++++++
 tb/tb_collision_judge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared constants for the arrow-lane hit judge: grade encoding, score
// increments, combo multiplier threshold and the lane state type.
package ddr_pkg;

  localparam logic [1:0] GRADE_NONE    = 2'b00;
  localparam logic [1:0] GRADE_GOOD    = 2'b01;
  localparam logic [1:0] GRADE_PERFECT = 2'b10;
  localparam logic [1:0] GRADE_MISS    = 2'b11;

  localparam int unsigned SCORE_PERFECT = 2;
  localparam int unsigned SCORE_GOOD    = 1;
  localparam int unsigned MULT_THRESH   = 10;

  typedef enum logic {
    LANE_IDLE  = 1'b0,
    LANE_ARMED = 1'b1
  } lane_state_e;

endpackage

// File: rtl/lane_judge.sv
// Per-lane note window: IDLE/ARMED FSM plus tick counter.
// grade_c is combinational and is registered by the parent.
module lane_judge
  import ddr_pkg::*;
#(
  parameter int unsigned WIN_W       = 8,
  parameter int unsigned PERFECT_WIN = 4,
  parameter int unsigned GOOD_WIN    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       press,
  input  logic       next,
  output logic [1:0] grade_c
);

  lane_state_e      state_q, state_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;

  // State and window counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and grade; press beats next beats tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grade_c = GRADE_NONE;
    case (state_q)
      LANE_IDLE: begin
        if (press) begin
          grade_c = next ? GRADE_PERFECT : GRADE_MISS;
        end else if (next) begin
          state_d = LANE_ARMED;
          cnt_d   = '0;
        end
      end
      LANE_ARMED: begin
        if (press) begin
          grade_c = (cnt_q <= WIN_W'(PERFECT_WIN)) ? GRADE_PERFECT : GRADE_GOOD;
          cnt_d   = '0;
          // A coincident next leaves the new note armed
          if (!next) state_d = LANE_IDLE;
        end else if (next) begin
          grade_c = GRADE_MISS;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == WIN_W'(GOOD_WIN - 1)) begin
            grade_c = GRADE_MISS;
            state_d = LANE_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + WIN_W'(1);
          end
        end
      end
      default: begin
        state_d = LANE_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/collision_judge.sv
// Multi-lane hit judge: press edge detection, per-lane windows, summed
// score and combo with saturation. Optional combo multiplier enabled by
// defining COLLISION_JUDGE_MULT_EN.
module collision_judge
  import ddr_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned WIN_W       = 8,
  parameter int unsigned PERFECT_WIN = 4,
  parameter int unsigned GOOD_WIN    = 12,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned COMBO_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [LANES-1:0]     btns,
  input  logic [LANES-1:0]     next,
  output logic [LANES-1:0]     correct_input,
  output logic [LANES-1:0]     miss,
  output logic [2*LANES-1:0]   grade,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo
);

  localparam int unsigned PTS_W = 8;
  localparam int unsigned HIT_W = 4;

  logic [LANES-1:0]   btns_q;
  logic [LANES-1:0]   press_c;
  logic [1:0]         lane_grade [LANES];

  logic [PTS_W-1:0]   pts_c;
  logic [PTS_W-1:0]   pts_scaled_c;
  logic [HIT_W-1:0]   hits_c;
  logic               any_miss_c;
  logic [LANES-1:0]   correct_c;
  logic [LANES-1:0]   miss_c;
  logic [2*LANES-1:0] grade_c;
  logic [SCORE_W:0]   score_sum_c;
  logic [COMBO_W:0]   combo_sum_c;
  logic [SCORE_W-1:0] score_d;
  logic [COMBO_W-1:0] combo_d;

  assign press_c = btns & ~btns_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_judge #(
      .WIN_W      (WIN_W),
      .PERFECT_WIN(PERFECT_WIN),
      .GOOD_WIN   (GOOD_WIN)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .press  (press_c[g]),
      .next   (next[g]),
      .grade_c(lane_grade[g])
    );
  end

  // Gather lane grades into pulses, points and hit/miss totals
  always_comb begin
    pts_c      = '0;
    hits_c     = '0;
    any_miss_c = 1'b0;
    correct_c  = '0;
    miss_c     = '0;
    grade_c    = '0;
    for (int i = 0; i < LANES; i++) begin
      grade_c[2*i +: 2] = lane_grade[i];
      case (lane_grade[i])
        GRADE_PERFECT: begin
          correct_c[i] = 1'b1;
          hits_c       = hits_c + HIT_W'(1);
          pts_c        = pts_c + PTS_W'(SCORE_PERFECT);
        end
        GRADE_GOOD: begin
          correct_c[i] = 1'b1;
          hits_c       = hits_c + HIT_W'(1);
          pts_c        = pts_c + PTS_W'(SCORE_GOOD);
        end
        GRADE_MISS: begin
          miss_c[i]  = 1'b1;
          any_miss_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Points after the optional combo multiplier
  always_comb begin
`ifdef COLLISION_JUDGE_MULT_EN
    pts_scaled_c = (combo >= COMBO_W'(MULT_THRESH)) ? (pts_c << 1) : pts_c;
`else
    pts_scaled_c = pts_c;
`endif
  end

  // Saturating score and combo updates; any miss clears the combo
  always_comb begin
    score_sum_c = {1'b0, score} + (SCORE_W+1)'(pts_scaled_c);
    combo_sum_c = {1'b0, combo} + (COMBO_W+1)'(hits_c);
    score_d     = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
    if (any_miss_c) combo_d = '0;
    else            combo_d = combo_sum_c[COMBO_W] ? '1 : combo_sum_c[COMBO_W-1:0];
  end

  // Edge register and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btns_q        <= '0;
      correct_input <= '0;
      miss          <= '0;
      grade         <= '0;
      score         <= '0;
      combo         <= '0;
    end else begin
      btns_q        <= btns;
      correct_input <= correct_c;
      miss          <= miss_c;
      grade         <= grade_c;
      score         <= score_d;
      combo         <= combo_d;
    end
  end

endmodule

// File: tb/tb_collision_judge.sv
// Directed bench for collision_judge with default parameters.
module tb_collision_judge;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] btns;
  logic [3:0] next;
  logic [3:0] correct_input;
  logic [3:0] miss;
  logic [7:0] grade;
  logic [15:0] score;
  logic [7:0] combo;

  int vectors;
  int miscompares;
  int pulses;

  collision_judge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .btns         (btns),
    .next         (next),
    .correct_input(correct_input),
    .miss         (miss),
    .grade        (grade),
    .score        (score),
    .combo        (combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] c, input logic [3:0] m,
                         input logic [7:0] g, input logic [15:0] s, input logic [7:0] k);
    chk({tag, ".correct"}, 32'(correct_input), 32'(c));
    chk({tag, ".miss"},    32'(miss),          32'(m));
    chk({tag, ".grade"},   32'(grade),         32'(g));
    chk({tag, ".score"},   32'(score),         32'(s));
    chk({tag, ".combo"},   32'(combo),         32'(k));
  endtask

  task automatic arm(input logic [3:0] lanes);
    next = lanes;
    cyc();
    next = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      if (miss != 4'h0) pulses++;
    end
    tick = 1'b0;
  endtask

  task automatic release_all();
    btns = '0;
    next = '0;
    tick = 1'b0;
    cyc();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    rst_n = 1'b0;
    tick  = 1'b0;
    btns  = '0;
    next  = '0;
    repeat (3) cyc();
    chk_out("reset", 4'h0, 4'h0, 8'h00, 16'd0, 8'd0);
    rst_n = 1'b1;
    cyc();

    // PERFECT after 2 ticks on lane 0
    arm(4'h1);
    ticks(2);
    btns = 4'h1;
    cyc();
    chk_out("perfect_l0", 4'h1, 4'h0, 8'h02, 16'd2, 8'd1);
    release_all();
    chk("perfect_l0_oneshot", 32'(correct_input), 32'h0);

    // GOOD after 7 ticks on lane 1
    arm(4'h2);
    ticks(7);
    btns = 4'h2;
    cyc();
    chk_out("good_l1", 4'h2, 4'h0, 8'h04, 16'd3, 8'd2);
    release_all();

    // Timeout on lane 2: silent through 11 ticks, MISS on the 12th
    arm(4'h4);
    pulses = 0;
    ticks(11);
    chk("timeout_early", 32'(pulses), 32'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_out("timeout_l2", 4'h0, 4'h4, 8'h30, 16'd3, 8'd0);
    cyc();
    chk("timeout_oneshot", 32'(miss), 32'h0);

    // next and press together in IDLE: PERFECT, lane stays idle
    btns = 4'h1;
    next = 4'h1;
    cyc();
    chk_out("idle_next_press", 4'h1, 4'h0, 8'h02, 16'd5, 8'd1);
    release_all();
    pulses = 0;
    ticks(14);
    chk("idle_stays_idle", 32'(pulses), 32'd0);

    // Stray press on lane 3 held for 20 cycles
    btns = 4'h8;
    cyc();
    chk_out("stray_l3", 4'h0, 4'h8, 8'hC0, 16'd5, 8'd0);
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      cyc();
      if (miss != 4'h0) pulses++;
    end
    chk("stray_held_single", 32'(pulses), 32'd0);
    release_all();

    // Two lanes PERFECT in the same cycle from score 0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    arm(4'h3);
    btns = 4'h3;
    cyc();
    chk_out("dual_perfect", 4'h3, 4'h0, 8'h0A, 16'd4, 8'd2);
    release_all();

    // next while ARMED: MISS the old note, counter restarts
    arm(4'h4);
    ticks(3);
    next = 4'h4;
    cyc();
    next = '0;
    chk_out("rearm_miss", 4'h0, 4'h4, 8'h30, 16'd4, 8'd0);
    ticks(5);
    btns = 4'h4;
    cyc();
    chk_out("rearm_good", 4'h4, 4'h0, 8'h10, 16'd5, 8'd1);
    release_all();

    // Press and next together while ARMED: hit grades, new note stays armed
    arm(4'h2);
    ticks(1);
    btns = 4'h2;
    next = 4'h2;
    cyc();
    chk_out("armed_press_next", 4'h2, 4'h0, 8'h08, 16'd7, 8'd2);
    release_all();
    pulses = 0;
    ticks(11);
    chk("new_note_early", 32'(pulses), 32'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_out("new_note_timeout", 4'h0, 4'h2, 8'h0C, 16'd7, 8'd0);

    // PERFECT window edge: counter 4 is PERFECT, 5 is GOOD
    arm(4'h8);
    ticks(4);
    btns = 4'h8;
    cyc();
    chk_out("edge_cnt4", 4'h8, 4'h0, 8'h80, 16'd9, 8'd1);
    release_all();
    arm(4'h8);
    ticks(5);
    btns = 4'h8;
    cyc();
    chk_out("edge_cnt5", 4'h8, 4'h0, 8'h40, 16'd10, 8'd2);
    release_all();

    // Reset mid-window: outputs clear and the note is dropped silently
    arm(4'h1);
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 4'h0, 4'h0, 8'h00, 16'd0, 8'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    pulses = 0;
    ticks(15);
    chk("midreset_no_miss", 32'(pulses), 32'd0);

    // Ten PERFECT hits to reach combo 10, then one more
    for (int i = 0; i < 10; i++) begin
      btns = 4'h1;
      next = 4'h1;
      cyc();
      release_all();
    end
    chk("combo10_score", 32'(score), 32'd20);
    chk("combo10_combo", 32'(combo), 32'd10);
    btns = 4'h1;
    next = 4'h1;
    cyc();
`ifdef COLLISION_JUDGE_MULT_EN
    chk("mult_score", 32'(score), 32'd24);
`else
    chk("nomult_score", 32'(score), 32'd22);
`endif
    chk("combo11", 32'(combo), 32'd11);
    release_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
